ps2_player_input: RTL and testbench

Receives scan codes from a PS/2 keyboard and turns them into the per-player movement and bomb signals that `bomberman_datapath` consumes: `p1_xdir`/`p1_xmov`/`p1_ydir`/`p1_ymov`/`p1_bomb` and the P2 equivalents. It is the transmit side of the datapath's keyboard interface. It sits between the board's PS2_CLK/PS2_DAT pins and the datapath, and runs entirely in the system clock domain.

---
 rtl/ps2_player_input.sv | 214 +++++++++++++++++++++
 tb/tb_ps2_player_input.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_player_input.sv
// PS/2 keyboard receiver and key decoder driving per-player movement and bomb requests.
// Optional build macro PS2_PARITY_CHECK_EN: when defined, frames with a bad start, stop
// or odd-parity bit are rejected with frame_error; otherwise every complete frame is accepted.
module ps2_player_input #(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic       p1_xmov,
   output logic       p1_xdir,
   output logic       p1_ymov,
   output logic       p1_ydir,
   output logic       p1_bomb,
   output logic       p2_xmov,
   output logic       p2_xdir,
   output logic       p2_ymov,
   output logic       p2_ydir,
   output logic       p2_bomb,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       frame_error
);

   localparam int unsigned IDLE_W  = 16;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned KEYS_W  = 10;
   localparam logic [IDLE_W-1:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]  STOP_BIT    = 4'd10;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_EXT     = 2'd1;
   localparam logic [1:0] ST_BRK     = 2'd2;
   localparam logic [1:0] ST_EXT_BRK = 2'd3;

   // Key flag indices: P1 up/left/down/right/bomb, P2 up/left/down/right/bomb
   localparam int unsigned K_P1_UP = 0, K_P1_LEFT = 1, K_P1_DOWN = 2, K_P1_RIGHT = 3, K_P1_BOMB = 4;
   localparam int unsigned K_P2_UP = 5, K_P2_LEFT = 6, K_P2_DOWN = 7, K_P2_RIGHT = 8, K_P2_BOMB = 9;

   logic              clk_meta, clk_sync, clk_prev;
   logic              dat_meta, dat_sync;
   logic              fall_c;
   logic [CNT_W-1:0]  bit_cnt;
   logic [IDLE_W-1:0] idle_cnt;
   logic [7:0]        data_sh;
   logic              timeout;
   logic              frame_ok_c;

   logic [1:0]        state, state_next;
   logic [KEYS_W-1:0] keys, keys_next, key_sel_c;
   logic              ext_c, brk_c;
   logic              p1_bomb_next, p2_bomb_next;

   // Two-flop synchronizers for the PS/2 pins plus a delay stage for edge detection
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta <= 1'b1;
         clk_sync <= 1'b1;
         clk_prev <= 1'b1;
         dat_meta <= 1'b1;
         dat_sync <= 1'b1;
      end else begin
         clk_meta <= ps2_clk;
         clk_sync <= clk_meta;
         clk_prev <= clk_sync;
         dat_meta <= ps2_dat;
         dat_sync <= dat_meta;
      end
   end

   assign fall_c = clk_prev & ~clk_sync;

`ifdef PS2_PARITY_CHECK_EN
   logic start_bit;
   logic par_acc;

   // Capture the start bit and accumulate XOR over data and parity bits
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         start_bit <= 1'b0;
         par_acc   <= 1'b0;
      end else if (fall_c) begin
         if (bit_cnt == '0) begin
            start_bit <= dat_sync;
            par_acc   <= 1'b0;
         end else if (bit_cnt != STOP_BIT) begin
            par_acc <= par_acc ^ dat_sync;
         end
      end
   end

   assign frame_ok_c = ~start_bit & dat_sync & par_acc;
`else
   assign frame_ok_c = 1'b1;
`endif

   // Frame receiver: bit counter, data shifter, idle timeout and result pulses
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt     <= '0;
         idle_cnt    <= '0;
         data_sh     <= '0;
         rx_byte     <= '0;
         rx_valid    <= 1'b0;
         frame_error <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         frame_error <= 1'b0;
         timeout     <= 1'b0;
         if (fall_c) begin
            idle_cnt <= '0;
            if (bit_cnt == STOP_BIT) begin
               bit_cnt <= '0;
               if (frame_ok_c) begin
                  rx_byte  <= data_sh;
                  rx_valid <= 1'b1;
               end else begin
                  frame_error <= 1'b1;
               end
            end else begin
               if (bit_cnt != '0 && bit_cnt != 4'd9) begin
                  data_sh <= {dat_sync, data_sh[7:1]};
               end
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (bit_cnt != '0) begin
            if (idle_cnt == TIMEOUT_VAL) begin
               bit_cnt     <= '0;
               idle_cnt    <= '0;
               frame_error <= 1'b1;
               timeout     <= 1'b1;
            end else begin
               idle_cnt <= idle_cnt + 16'd1;
            end
         end else begin
            idle_cnt <= '0;
         end
      end
   end

   // Decoder state, held-key flags and bomb pulses
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         keys    <= '0;
         p1_bomb <= 1'b0;
         p2_bomb <= 1'b0;
      end else begin
         state   <= state_next;
         keys    <= keys_next;
         p1_bomb <= p1_bomb_next;
         p2_bomb <= p2_bomb_next;
      end
   end

   // Decoder next-state: prefix tracking, key lookup and make/break application
   always_comb begin
      state_next   = state;
      keys_next    = keys;
      p1_bomb_next = 1'b0;
      p2_bomb_next = 1'b0;
      key_sel_c    = '0;
      ext_c        = (state == ST_EXT) || (state == ST_EXT_BRK);
      brk_c        = (state == ST_BRK) || (state == ST_EXT_BRK);

      case ({ext_c, rx_byte})
         {1'b0, 8'h1D}: key_sel_c[K_P1_UP]    = 1'b1;
         {1'b0, 8'h1C}: key_sel_c[K_P1_LEFT]  = 1'b1;
         {1'b0, 8'h1B}: key_sel_c[K_P1_DOWN]  = 1'b1;
         {1'b0, 8'h23}: key_sel_c[K_P1_RIGHT] = 1'b1;
         {1'b0, 8'h29}: key_sel_c[K_P1_BOMB]  = 1'b1;
         {1'b0, 8'h5A}: key_sel_c[K_P2_BOMB]  = 1'b1;
         {1'b1, 8'h75}: key_sel_c[K_P2_UP]    = 1'b1;
         {1'b1, 8'h6B}: key_sel_c[K_P2_LEFT]  = 1'b1;
         {1'b1, 8'h72}: key_sel_c[K_P2_DOWN]  = 1'b1;
         {1'b1, 8'h74}: key_sel_c[K_P2_RIGHT] = 1'b1;
         default:       key_sel_c             = '0;
      endcase

      if (timeout) begin
         state_next = ST_IDLE;
      end else if (rx_valid) begin
         if (state == ST_IDLE && rx_byte == 8'hE0) begin
            state_next = ST_EXT;
         end else if (state == ST_IDLE && rx_byte == 8'hF0) begin
            state_next = ST_BRK;
         end else if (state == ST_EXT && rx_byte == 8'hF0) begin
            state_next = ST_EXT_BRK;
         end else begin
            state_next = ST_IDLE;
            if (brk_c) begin
               keys_next = keys & ~key_sel_c;
            end else begin
               keys_next    = keys | key_sel_c;
               p1_bomb_next = key_sel_c[K_P1_BOMB] & ~keys[K_P1_BOMB];
               p2_bomb_next = key_sel_c[K_P2_BOMB] & ~keys[K_P2_BOMB];
            end
         end
      end
   end

   // Movement decode: opposing keys on one axis cancel
   assign p1_xmov = keys[K_P1_LEFT] ^ keys[K_P1_RIGHT];
   assign p1_xdir = keys[K_P1_RIGHT] & ~keys[K_P1_LEFT];
   assign p1_ymov = keys[K_P1_UP] ^ keys[K_P1_DOWN];
   assign p1_ydir = keys[K_P1_DOWN] & ~keys[K_P1_UP];
   assign p2_xmov = keys[K_P2_LEFT] ^ keys[K_P2_RIGHT];
   assign p2_xdir = keys[K_P2_RIGHT] & ~keys[K_P2_LEFT];
   assign p2_ymov = keys[K_P2_UP] ^ keys[K_P2_DOWN];
   assign p2_ydir = keys[K_P2_DOWN] & ~keys[K_P2_UP];

endmodule

// File: tb/tb_ps2_player_input.sv
// Self-checking bench for ps2_player_input: directed scenarios plus random scan-code traffic
// compared against a key-set model. Honours PS2_PARITY_CHECK_EN in the same way as the design.
module tb_ps2_player_input;

   localparam int unsigned TMO  = 300;
   localparam int unsigned HALF = 15;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic       p1_xmov, p1_xdir, p1_ymov, p1_ydir, p1_bomb;
   logic       p2_xmov, p2_xdir, p2_ymov, p2_ydir, p2_bomb;
   logic [7:0] rx_byte;
   logic       rx_valid, frame_error;
   logic [7:0] moves_obs;
   logic [20:0] all_obs;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   ps2_player_input #(.TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .p1_xmov(p1_xmov), .p1_xdir(p1_xdir), .p1_ymov(p1_ymov), .p1_ydir(p1_ydir), .p1_bomb(p1_bomb),
      .p2_xmov(p2_xmov), .p2_xdir(p2_xdir), .p2_ymov(p2_ymov), .p2_ydir(p2_ydir), .p2_bomb(p2_bomb),
      .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_error(frame_error)
   );

   assign moves_obs = {p1_xmov, p1_xdir, p1_ymov, p1_ydir, p2_xmov, p2_xdir, p2_ymov, p2_ydir};
   assign all_obs   = {moves_obs, p1_bomb, p2_bomb, rx_byte, rx_valid, frame_error, 1'b0};

   // Pulse counters sampled on the inactive edge
   int   rx_cnt = 0, fe_cnt = 0, p1b_cnt = 0, p2b_cnt = 0, wide_cnt = 0;
   logic p1b_d = 1'b0, p2b_d = 1'b0;
   always @(negedge clock) begin
      if (rx_valid) rx_cnt++;
      if (frame_error) fe_cnt++;
      if (p1_bomb) p1b_cnt++;
      if (p2_bomb) p2b_cnt++;
      if ((p1_bomb && p1b_d) || (p2_bomb && p2b_d)) wide_cnt++;
      p1b_d = p1_bomb;
      p2b_d = p2_bomb;
   end

   // Reference model: set of held keys by name plus pending prefix bytes
   bit         held[string];
   bit         m_ext = 1'b0, m_brk = 1'b0;
   int         exp_rx = 0, exp_fe = 0, exp_p1b = 0, exp_p2b = 0;
   logic [7:0] last_byte = 8'h00;

   function automatic string key_name(input bit ext, input logic [7:0] b);
      string k;
      k = "";
      if (!ext) begin
         case (b)
            8'h1D: k = "p1_up";
            8'h1C: k = "p1_left";
            8'h1B: k = "p1_down";
            8'h23: k = "p1_right";
            8'h29: k = "p1_bomb";
            8'h5A: k = "p2_bomb";
            default: k = "";
         endcase
      end else begin
         case (b)
            8'h75: k = "p2_up";
            8'h6B: k = "p2_left";
            8'h72: k = "p2_down";
            8'h74: k = "p2_right";
            default: k = "";
         endcase
      end
      return k;
   endfunction

   function automatic bit is_held(input string k);
      if (held.exists(k)) return held[k];
      return 1'b0;
   endfunction

   function automatic logic [3:0] axis_pair(input string p);
      bit l, r, u, d;
      l = is_held({p, "_left"});
      r = is_held({p, "_right"});
      u = is_held({p, "_up"});
      d = is_held({p, "_down"});
      return {l != r, r && !l, u != d, d && !u};
   endfunction

   function automatic logic [7:0] exp_moves();
      return {axis_pair("p1"), axis_pair("p2")};
   endfunction

   task automatic model_step(input logic [7:0] b);
      string k;
      exp_rx++;
      last_byte = b;
      if (b == 8'hE0 && !m_ext && !m_brk) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0 && !m_brk) begin
         m_brk = 1'b1;
      end else begin
         k = key_name(m_ext, b);
         if (k != "") begin
            if (m_brk) begin
               held[k] = 1'b0;
            end else begin
               if (k == "p1_bomb" && !is_held(k)) exp_p1b++;
               if (k == "p2_bomb" && !is_held(k)) exp_p2b++;
               held[k] = 1'b1;
            end
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   function automatic logic [10:0] frame_of(input logic [7:0] b, input bit bad);
      logic par;
      par = ~(^b);
      if (bad) par = ~par;
      return {1'b1, par, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         ps2_dat = bits[i];
         repeat (HALF) @(negedge clock);
         ps2_clk = 1'b0;
         repeat (HALF) @(negedge clock);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad);
      send_bits(frame_of(b, bad), 11);
      repeat (10) @(negedge clock);
`ifdef PS2_PARITY_CHECK_EN
      if (bad) exp_fe++;
      else model_step(b);
`else
      model_step(b);
`endif
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      held.delete();
      m_ext = 1'b0;
      m_brk = 1'b0;
      last_byte = 8'h00;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (4) @(negedge clock);
      checks++;
      if (all_obs !== 21'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", all_obs);
      end
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
   endtask

   task automatic test_p1_move();
      int rx0;
      rx0 = rx_cnt;
      send_byte(8'h1D, 1'b0);
      checks++;
      if (rx_byte !== 8'h1D) begin
         errors++;
         $display("FAIL t1_rx_byte: got %h expected 1d", rx_byte);
      end
      checks++;
      if (rx_cnt - rx0 !== 1) begin
         errors++;
         $display("FAIL t1_rx_valid_pulses: got %0d expected 1", rx_cnt - rx0);
      end
      checks++;
      if ({p1_ymov, p1_ydir} !== 2'b10) begin
         errors++;
         $display("FAIL t1_up: got ymov/ydir %b expected 10", {p1_ymov, p1_ydir});
      end
      send_byte(8'hF0, 1'b0);
      send_byte(8'h1D, 1'b0);
      checks++;
      if (p1_ymov !== 1'b0 || moves_obs !== exp_moves()) begin
         errors++;
         $display("FAIL t1_release: got %b expected %b", moves_obs, exp_moves());
      end
   endtask

   task automatic test_bomb_typematic();
      int b0, w0;
      b0 = p1b_cnt;
      w0 = wide_cnt;
      send_byte(8'h29, 1'b0);
      send_byte(8'h29, 1'b0);
      send_byte(8'h29, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h29, 1'b0);
      send_byte(8'h29, 1'b0);
      checks++;
      if (p1b_cnt - b0 !== 2) begin
         errors++;
         $display("FAIL t2_bomb_pulses: got %0d expected 2", p1b_cnt - b0);
      end
      checks++;
      if (wide_cnt - w0 !== 0) begin
         errors++;
         $display("FAIL t2_bomb_width: got %0d wide pulses expected 0", wide_cnt - w0);
      end
   endtask

   task automatic test_p2_extended();
      send_byte(8'hE0, 1'b0);
      send_byte(8'h74, 1'b0);
      checks++;
      if ({p2_xmov, p2_xdir} !== 2'b11) begin
         errors++;
         $display("FAIL t3_right: got %b expected 11", {p2_xmov, p2_xdir});
      end
      send_byte(8'hE0, 1'b0);
      send_byte(8'h6B, 1'b0);
      checks++;
      if (p2_xmov !== 1'b0) begin
         errors++;
         $display("FAIL t3_both: got xmov %b expected 0", p2_xmov);
      end
      send_byte(8'hE0, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h74, 1'b0);
      checks++;
      if ({p2_xmov, p2_xdir} !== 2'b10 || moves_obs !== exp_moves()) begin
         errors++;
         $display("FAIL t3_left: got %b expected %b", moves_obs, exp_moves());
      end
   endtask

   task automatic test_p2_enter();
      int b0;
      b0 = p2b_cnt;
      send_byte(8'h5A, 1'b0);
      checks++;
      if (p2b_cnt - b0 !== 1) begin
         errors++;
         $display("FAIL t4_enter_pulse: got %0d expected 1", p2b_cnt - b0);
      end
      send_byte(8'hF0, 1'b0);
      send_byte(8'h5A, 1'b0);
      b0 = p2b_cnt;
      send_byte(8'hE0, 1'b0);
      send_byte(8'h5A, 1'b0);
      checks++;
      if (p2b_cnt - b0 !== 0 || moves_obs !== exp_moves()) begin
         errors++;
         $display("FAIL t4_ext_enter: got %0d pulses moves %b expected 0 pulses moves %b",
                  p2b_cnt - b0, moves_obs, exp_moves());
      end
      b0 = p2b_cnt;
      send_byte(8'h5A, 1'b0);
      checks++;
      if (p2b_cnt - b0 !== 1) begin
         errors++;
         $display("FAIL t4_enter_after_ext: got %0d expected 1", p2b_cnt - b0);
      end
   endtask

   task automatic test_parity();
      int rx0, fe0;
      do_reset();
      rx0 = rx_cnt;
      fe0 = fe_cnt;
      send_byte(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
      checks++;
      if (fe_cnt - fe0 !== 1 || rx_cnt - rx0 !== 0) begin
         errors++;
         $display("FAIL t5_reject: got fe %0d rx %0d expected fe 1 rx 0", fe_cnt - fe0, rx_cnt - rx0);
      end
      checks++;
      if (p1_xmov !== 1'b0) begin
         errors++;
         $display("FAIL t5_no_move: got %b expected 0", p1_xmov);
      end
`else
      checks++;
      if (fe_cnt - fe0 !== 0 || rx_cnt - rx0 !== 1) begin
         errors++;
         $display("FAIL t5_accept: got fe %0d rx %0d expected fe 0 rx 1", fe_cnt - fe0, rx_cnt - rx0);
      end
      checks++;
      if ({p1_xmov, p1_xdir} !== 2'b10) begin
         errors++;
         $display("FAIL t5_left: got %b expected 10", {p1_xmov, p1_xdir});
      end
`endif
   endtask

   task automatic test_timeout();
      int rx0, fe0;
      do_reset();
      send_byte(8'hF0, 1'b0);
      rx0 = rx_cnt;
      fe0 = fe_cnt;
      send_bits(frame_of(8'h55, 1'b0), 5);
      repeat (TMO + 20) @(negedge clock);
      exp_fe++;
      m_ext = 1'b0;
      m_brk = 1'b0;
      checks++;
      if (fe_cnt - fe0 !== 1 || rx_cnt - rx0 !== 0) begin
         errors++;
         $display("FAIL t6_timeout: got fe %0d rx %0d expected fe 1 rx 0", fe_cnt - fe0, rx_cnt - rx0);
      end
      send_byte(8'h23, 1'b0);
      checks++;
      if (p1_xdir !== 1'b1 || rx_byte !== 8'h23) begin
         errors++;
         $display("FAIL t6_after_timeout: got xdir %b byte %h expected 1 23", p1_xdir, rx_byte);
      end
   endtask

   task automatic test_reset_mid_frame();
      send_bits(frame_of(8'h1B, 1'b0), 6);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (all_obs !== 21'd0) begin
         errors++;
         $display("FAIL t6_mid_reset: got %h expected 0", all_obs);
      end
      held.delete();
      m_ext = 1'b0;
      m_brk = 1'b0;
      last_byte = 8'h00;
      repeat (3) @(negedge clock);
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      send_byte(8'h1B, 1'b0);
      checks++;
      if ({p1_ymov, p1_ydir} !== 2'b11 || rx_byte !== 8'h1B) begin
         errors++;
         $display("FAIL t6_after_reset: got %b byte %h expected 11 1b", {p1_ymov, p1_ydir}, rx_byte);
      end
   endtask

   task automatic test_random();
      logic [7:0] codes [15];
      logic [7:0] b;
      bit         bad;
      codes = '{8'hE0, 8'hF0, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A,
                8'h75, 8'h6B, 8'h72, 8'h74, 8'h12, 8'hE0, 8'hF0};
      do_reset();
      exp_rx = rx_cnt;
      exp_fe = fe_cnt;
      exp_p1b = p1b_cnt;
      exp_p2b = p2b_cnt;
      for (int i = 0; i < 40; i++) begin
         b = codes[$urandom_range(0, 14)];
         bad = ($urandom_range(0, 7) == 0);
         send_byte(b, bad);
         checks++;
         if (moves_obs !== exp_moves()) begin
            errors++;
            $display("FAIL rnd_moves[%0d]: got %b expected %b", i, moves_obs, exp_moves());
         end
         checks++;
         if (rx_byte !== last_byte) begin
            errors++;
            $display("FAIL rnd_rx_byte[%0d]: got %h expected %h", i, rx_byte, last_byte);
         end
         checks++;
         if (rx_cnt !== exp_rx || fe_cnt !== exp_fe) begin
            errors++;
            $display("FAIL rnd_pulses[%0d]: got rx %0d fe %0d expected rx %0d fe %0d",
                     i, rx_cnt, fe_cnt, exp_rx, exp_fe);
         end
         checks++;
         if (p1b_cnt !== exp_p1b || p2b_cnt !== exp_p2b) begin
            errors++;
            $display("FAIL rnd_bombs[%0d]: got %0d/%0d expected %0d/%0d",
                     i, p1b_cnt, p2b_cnt, exp_p1b, exp_p2b);
         end
      end
      checks++;
      if (wide_cnt !== 0) begin
         errors++;
         $display("FAIL bomb_width_total: got %0d wide pulses expected 0", wide_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_p1_move();
      test_bomb_typematic();
      test_p2_extended();
      test_p2_enter();
      test_parity();
      test_timeout();
      test_reset_mid_frame();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
